// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART RX controller.
// Holds the sequencer state encoding and baud defaults.
package uart_ctrl_pkg;

   localparam int          BAUD_W     = 32;
   localparam logic [31:0] DEF_BAUD_C = 32'd115200;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_DRAIN,
      ST_PROG,
      ST_SETTLE,
      ST_RUN
   } state_t;

endpackage

// File: rtl/uart_rx_ctrl_idle_timer.sv
// Idle timer for the RX FIFO: saturating counter plus timeout IRQ.
// Counts cycles with data parked in the FIFO and no new bytes.
module uart_idle_timer #(
   parameter int TIMEOUT_CYC = 4000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_accept,
   input  logic i_empty,
   output logic o_irq
);

   localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);
   localparam logic TEN = (TIMEOUT_CYC != 0);

   logic [TW-1:0] r_timer;
   logic          r_irq;
   logic          w_hit;

   assign w_hit = TEN && (r_timer == TMAX);

   // Count idle cycles, restart on new traffic or an empty FIFO
   always_ff @(posedge i_clk) begin
      if (i_rst || i_accept || i_empty) begin
         r_timer <= '0;
      end else if (r_timer != TMAX) begin
         r_timer <= r_timer + TW'(1);
      end
   end

   // Registered IRQ, dropped as soon as traffic or emptiness is seen
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= w_hit && !i_empty && !i_accept;
      end
   end

   assign o_irq = r_irq;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequencer for the uart_rx receiver and its RX FIFO.
// Handles baud (re)programming, byte capture, counters and timeout.
module uart_rx_ctrl
   import uart_ctrl_pkg::*;
#(
   parameter logic [BAUD_W-1:0] DEF_BAUD    = DEF_BAUD_C,
   parameter int                SETTLE_CYC  = 16,
   parameter int                TIMEOUT_CYC = 4000,
   parameter int                CNT_W       = 16
) (
   input  logic              CLKip,
   input  logic              RSTi,
   input  logic              ENi,
   input  logic              CFG_WEi,
   input  logic [BAUD_W-1:0] CFG_BAUDi,
   output logic              CFG_BUSYo,
   input  logic              UART_DONEi,
   input  logic              UART_READYi,
   input  logic [7:0]        UART_DATAi,
   output logic              UART_BAUD_WEo,
   output logic [BAUD_W-1:0] UART_BAUDo,
   output logic              FIFO_WEo,
   output logic [7:0]        FIFO_WDo,
   input  logic              FIFO_FULLi,
   input  logic              FIFO_EMPTYi,
   input  logic              CNT_CLRi,
   output logic [CNT_W-1:0]  RX_CNTo,
   output logic [CNT_W-1:0]  OVF_CNTo,
   output logic              OVF_STKo,
   output logic              IRQ_TOo
);

   localparam int SW = $clog2(SETTLE_CYC + 1);

   state_t            r_state;
   state_t            w_state_nx;
   logic [SW-1:0]     r_settle;
   logic [BAUD_W-1:0] r_baud;
   logic              r_fifo_we;
   logic [7:0]        r_fifo_wd;
   logic [CNT_W-1:0]  r_rx_cnt;
   logic [CNT_W-1:0]  r_ovf_cnt;
   logic              r_ovf_stk;
   logic              w_cap_st;
   logic              w_cap;
   logic              w_accept;
   logic              w_drop;
   logic              w_irq;

   // State register
   always_ff @(posedge CLKip) begin
      if (RSTi) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Next-state logic for the drain/program/settle sequence
   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         ST_INIT:   w_state_nx = ST_PROG;
         ST_RUN:    if (CFG_WEi) w_state_nx = ST_DRAIN;
         ST_DRAIN:  if (UART_READYi) w_state_nx = ST_PROG;
         ST_PROG:   w_state_nx = ST_SETTLE;
         ST_SETTLE: if (r_settle == '0) w_state_nx = ST_RUN;
         default:   w_state_nx = ST_INIT;
      endcase
   end

   // Settle down-counter, loaded while the baud strobe is out
   always_ff @(posedge CLKip) begin
      if (RSTi) begin
         r_settle <= '0;
      end else if (r_state == ST_PROG) begin
         r_settle <= SW'(SETTLE_CYC - 1);
      end else if (r_state == ST_SETTLE && r_settle != '0) begin
         r_settle <= r_settle - SW'(1);
      end
   end

   // Baud register: default on reset, host value accepted only in RUN
   always_ff @(posedge CLKip) begin
      if (RSTi) begin
         r_baud <= DEF_BAUD;
      end else if (r_state == ST_RUN && CFG_WEi) begin
         r_baud <= CFG_BAUDi;
      end
   end

   assign w_cap_st = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign w_cap    = w_cap_st && UART_DONEi && ENi;
   assign w_accept = w_cap && !FIFO_FULLi;
   assign w_drop   = w_cap && FIFO_FULLi;

   // One-cycle registered FIFO write of each accepted byte
   always_ff @(posedge CLKip) begin
      if (RSTi) begin
         r_fifo_we <= 1'b0;
         r_fifo_wd <= '0;
      end else begin
         r_fifo_we <= w_accept;
         if (w_accept) r_fifo_wd <= UART_DATAi;
      end
   end

   // Received-byte counter; a same-cycle event survives the clear
   always_ff @(posedge CLKip) begin
      if (RSTi) begin
         r_rx_cnt <= '0;
      end else if (CNT_CLRi) begin
         r_rx_cnt <= w_accept ? CNT_W'(1) : '0;
      end else if (w_accept) begin
         r_rx_cnt <= r_rx_cnt + CNT_W'(1);
      end
   end

   // Saturating overflow counter and sticky flag
   always_ff @(posedge CLKip) begin
      if (RSTi) begin
         r_ovf_cnt <= '0;
         r_ovf_stk <= 1'b0;
      end else if (CNT_CLRi) begin
         r_ovf_cnt <= w_drop ? CNT_W'(1) : '0;
         r_ovf_stk <= w_drop;
      end else if (w_drop) begin
         if (r_ovf_cnt != '1) r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
         r_ovf_stk <= 1'b1;
      end
   end

   uart_idle_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_idle (
      .i_clk    (CLKip),
      .i_rst    (RSTi),
      .i_accept (w_accept),
      .i_empty  (FIFO_EMPTYi),
      .o_irq    (w_irq)
   );

   assign CFG_BUSYo     = (r_state != ST_RUN);
   assign UART_BAUD_WEo = (r_state == ST_PROG);
   assign UART_BAUDo    = r_baud;
   assign FIFO_WEo      = r_fifo_we;
   assign FIFO_WDo      = r_fifo_wd;
   assign RX_CNTo       = r_rx_cnt;
   assign OVF_CNTo      = r_ovf_cnt;
   assign OVF_STKo      = r_ovf_stk;
   assign IRQ_TOo       = w_irq;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl.
// Table of single-cycle capture vectors plus multi-cycle sequences.
module tb_uart_rx_ctrl;

   logic        CLKip = 1'b0;
   logic        RSTi;
   logic        ENi;
   logic        CFG_WEi;
   logic [31:0] CFG_BAUDi;
   logic        CFG_BUSYo;
   logic        UART_DONEi;
   logic        UART_READYi;
   logic [7:0]  UART_DATAi;
   logic        UART_BAUD_WEo;
   logic [31:0] UART_BAUDo;
   logic        FIFO_WEo;
   logic [7:0]  FIFO_WDo;
   logic        FIFO_FULLi;
   logic        FIFO_EMPTYi;
   logic        CNT_CLRi;
   logic [15:0] RX_CNTo;
   logic [15:0] OVF_CNTo;
   logic        OVF_STKo;
   logic        IRQ_TOo;

   always #5 CLKip = ~CLKip;

   uart_rx_ctrl #(
      .DEF_BAUD    (32'd115200),
      .SETTLE_CYC  (16),
      .TIMEOUT_CYC (8),
      .CNT_W       (16)
   ) dut (
      .CLKip         (CLKip),
      .RSTi          (RSTi),
      .ENi           (ENi),
      .CFG_WEi       (CFG_WEi),
      .CFG_BAUDi     (CFG_BAUDi),
      .CFG_BUSYo     (CFG_BUSYo),
      .UART_DONEi    (UART_DONEi),
      .UART_READYi   (UART_READYi),
      .UART_DATAi    (UART_DATAi),
      .UART_BAUD_WEo (UART_BAUD_WEo),
      .UART_BAUDo    (UART_BAUDo),
      .FIFO_WEo      (FIFO_WEo),
      .FIFO_WDo      (FIFO_WDo),
      .FIFO_FULLi    (FIFO_FULLi),
      .FIFO_EMPTYi   (FIFO_EMPTYi),
      .CNT_CLRi      (CNT_CLRi),
      .RX_CNTo       (RX_CNTo),
      .OVF_CNTo      (OVF_CNTo),
      .OVF_STKo      (OVF_STKo),
      .IRQ_TOo       (IRQ_TOo)
   );

   typedef struct {
      logic        done;
      logic        en;
      logic        full;
      logic        clr;
      logic [7:0]  data;
      logic        we;
      logic [7:0]  wd;
      logic [15:0] rx;
      logic [15:0] ovf;
      logic        stk;
   } vec_t;

   vec_t tbl[11];
   int   total = 0;
   int   bad   = 0;

   task automatic tick;
      @(posedge CLKip);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(logic d, logic e, logic f, logic c,
                               logic [7:0] dt, logic w, logic [7:0] wd,
                               logic [15:0] rx, logic [15:0] ovf,
                               logic stk);
      vec_t v;
      v.done = d; v.en = e; v.full = f; v.clr = c; v.data = dt;
      v.we = w; v.wd = wd; v.rx = rx; v.ovf = ovf; v.stk = stk;
      return v;
   endfunction

   initial begin
      int n;
      int first;
      logic ok;

      //             done en full clr data   we  wd     rx  ovf stk
      tbl[0]  = mk(1, 1, 0, 0, 8'h55, 1, 8'h55, 1, 0, 0);
      tbl[1]  = mk(1, 1, 0, 0, 8'hA3, 1, 8'hA3, 2, 0, 0);
      tbl[2]  = mk(0, 1, 0, 0, 8'h00, 0, 8'h00, 2, 0, 0);
      tbl[3]  = mk(1, 0, 0, 0, 8'h11, 0, 8'h00, 2, 0, 0);
      tbl[4]  = mk(1, 1, 1, 0, 8'h21, 0, 8'h00, 2, 1, 1);
      tbl[5]  = mk(1, 1, 1, 0, 8'h22, 0, 8'h00, 2, 2, 1);
      tbl[6]  = mk(1, 1, 1, 0, 8'h23, 0, 8'h00, 2, 3, 1);
      tbl[7]  = mk(1, 1, 1, 1, 8'h24, 0, 8'h00, 0, 1, 1);
      tbl[8]  = mk(0, 1, 0, 1, 8'h00, 0, 8'h00, 0, 0, 0);
      tbl[9]  = mk(1, 1, 0, 1, 8'h3C, 1, 8'h3C, 1, 0, 0);
      tbl[10] = mk(0, 1, 0, 0, 8'h00, 0, 8'h00, 1, 0, 0);

      RSTi = 1; ENi = 0; CFG_WEi = 0; CFG_BAUDi = 0;
      UART_DONEi = 0; UART_READYi = 1; UART_DATAi = 0;
      FIFO_FULLi = 0; FIFO_EMPTYi = 1; CNT_CLRi = 0;
      tick; tick; tick;

      chk("rst_busy", CFG_BUSYo, 1);
      chk("rst_baud", UART_BAUDo, 115200);
      chk("rst_bwe", UART_BAUD_WEo, 0);
      chk("rst_fwe", FIFO_WEo, 0);
      chk("rst_rx", RX_CNTo, 0);
      chk("rst_ovf", OVF_CNTo, 0);
      chk("rst_stk", OVF_STKo, 0);
      chk("rst_irq", IRQ_TOo, 0);

      RSTi = 0;
      tick;
      chk("init_bwe", UART_BAUD_WEo, 1);
      chk("init_baud", UART_BAUDo, 115200);
      n = 1;
      while (CFG_BUSYo && n < 40) begin
         tick;
         n++;
      end
      chk("busy_len", n, 18);
      chk("run_bwe", UART_BAUD_WEo, 0);

      ENi = 1;
      for (int i = 0; i < 11; i++) begin
         UART_DONEi = tbl[i].done;
         ENi        = tbl[i].en;
         FIFO_FULLi = tbl[i].full;
         CNT_CLRi   = tbl[i].clr;
         UART_DATAi = tbl[i].data;
         tick;
         chk($sformatf("v%0d_we", i), FIFO_WEo, tbl[i].we);
         if (tbl[i].we)
            chk($sformatf("v%0d_wd", i), FIFO_WDo, tbl[i].wd);
         chk($sformatf("v%0d_rx", i), RX_CNTo, tbl[i].rx);
         chk($sformatf("v%0d_ovf", i), OVF_CNTo, tbl[i].ovf);
         chk($sformatf("v%0d_stk", i), OVF_STKo, tbl[i].stk);
         chk($sformatf("v%0d_irq", i), IRQ_TOo, 0);
      end
      UART_DONEi = 0; ENi = 1; FIFO_FULLi = 0; CNT_CLRi = 0;

      CFG_BAUDi = 32'd9600; CFG_WEi = 1; UART_READYi = 0;
      tick;
      CFG_WEi = 0;
      chk("drn_busy", CFG_BUSYo, 1);
      chk("drn_baud", UART_BAUDo, 9600);
      ok = 1;
      for (int k = 0; k < 50; k++) begin
         UART_DONEi = (k == 20);
         UART_DATAi = 8'h7E;
         tick;
         UART_DONEi = 0;
         if (UART_BAUD_WEo || !CFG_BUSYo) ok = 0;
         if (k == 20) begin
            chk("drn_we", FIFO_WEo, 1);
            chk("drn_wd", FIFO_WDo, 8'h7E);
         end
      end
      chk("drn_hold", ok, 1);
      chk("drn_rx", RX_CNTo, 2);
      UART_READYi = 1;
      tick;
      chk("prg_bwe", UART_BAUD_WEo, 1);
      chk("prg_baud", UART_BAUDo, 9600);
      tick;
      UART_DONEi = 1; UART_DATAi = 8'h99;
      CFG_WEi = 1; CFG_BAUDi = 32'd1200;
      tick;
      UART_DONEi = 0; CFG_WEi = 0;
      chk("stl_we", FIFO_WEo, 0);
      chk("stl_rx", RX_CNTo, 2);
      chk("stl_baud", UART_BAUDo, 9600);
      n = 0;
      while (CFG_BUSYo && n < 40) begin
         tick;
         n++;
      end
      chk("stl_done", CFG_BUSYo, 0);
      tick;
      chk("run_busy", CFG_BUSYo, 0);
      chk("run_baud", UART_BAUDo, 9600);

      FIFO_EMPTYi = 0; UART_DONEi = 1; UART_DATAi = 8'h01;
      tick;
      UART_DONEi = 0;
      chk("to_we", FIFO_WEo, 1);
      chk("to_rx", RX_CNTo, 3);
      first = 0;
      for (int k = 1; k <= 12; k++) begin
         tick;
         if (IRQ_TOo && first == 0) first = k;
      end
      chk("to_lat", first, 9);
      FIFO_EMPTYi = 1;
      tick;
      chk("to_empty", IRQ_TOo, 0);
      FIFO_EMPTYi = 0;
      for (int k = 0; k < 12; k++) tick;
      chk("to_rise2", IRQ_TOo, 1);
      UART_DONEi = 1; UART_DATAi = 8'h02;
      tick;
      UART_DONEi = 0;
      chk("to_acc", IRQ_TOo, 0);
      chk("to_rx2", RX_CNTo, 4);
      FIFO_EMPTYi = 1;

      CFG_BAUDi = 32'd9600; CFG_WEi = 1;
      tick;
      CFG_WEi = 0;
      tick; tick; tick; tick;
      chk("r6_busy", CFG_BUSYo, 1);
      chk("r6_baud", UART_BAUDo, 9600);
      RSTi = 1;
      tick;
      chk("r6_rbaud", UART_BAUDo, 115200);
      chk("r6_rx", RX_CNTo, 0);
      chk("r6_bwe0", UART_BAUD_WEo, 0);
      RSTi = 0;
      tick;
      chk("r6_bwe", UART_BAUD_WEo, 1);
      chk("r6_pbaud", UART_BAUDo, 115200);
      n = 1;
      while (CFG_BUSYo && n < 40) begin
         tick;
         n++;
      end
      chk("r6_len", n, 18);
      chk("r6_ovf", OVF_CNTo, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
